// File: rtl/alu_pkg.sv
// Shared opcode encodings, widths and flag layout for the ALU result stage.
package alu_pkg;

    localparam int unsigned ALU_W  = 4;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OP_W-1:0] OP_AND = 2'b00;
    localparam logic [OP_W-1:0] OP_OR  = 2'b01;
    localparam logic [OP_W-1:0] OP_ADD = 2'b10;
    localparam logic [OP_W-1:0] OP_SUB = 2'b11;

    // Flag bit order {par, carry, neg, zero}; zero is bit 0.
    typedef struct packed {
        logic par;
        logic carry;
        logic neg;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/alu_res_fifo2.sv
// Two-entry FIFO with the head held in a dedicated register so the head bus is a flop output.
module alu_res_fifo2 #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    localparam int unsigned OCC_W = 2;

    logic [OCC_W-1:0] occ_q, occ_d;
    logic [DW-1:0]    slot0_q, slot0_d;
    logic [DW-1:0]    slot1_q, slot1_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ_q == OCC_W'(2));
    assign empty   = (occ_q == OCC_W'(0));
    assign head    = slot0_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // slot0 is only rewritten on real data movement, so an emptied FIFO keeps its last head.
    always_comb begin
        occ_d   = occ_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case (occ_q)
            OCC_W'(0): begin
                if (do_push) begin
                    slot0_d = din;
                    occ_d   = OCC_W'(1);
                end
            end
            OCC_W'(1): begin
                case ({do_push, do_pop})
                    2'b11: slot0_d = din;
                    2'b10: begin
                        slot1_d = din;
                        occ_d   = OCC_W'(2);
                    end
                    2'b01: occ_d = OCC_W'(0);
                    default: ;
                endcase
            end
            OCC_W'(2): begin
                if (do_pop) begin
                    slot0_d = slot1_q;
                    occ_d   = OCC_W'(1);
                end
            end
            default: occ_d = OCC_W'(0);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q   <= '0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            occ_q   <= occ_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: computes status flags on capture and buffers two results
// behind a valid/ready interface.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W,
    parameter int unsigned OPW   = OP_W,
    parameter int unsigned CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_cout,
    input  logic [OPW-1:0]   in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [OPW-1:0]   out_op,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_par,
    output logic [CNTW-1:0]  res_cnt
);

    localparam int unsigned ENTRY_W = WIDTH + OPW + FLAG_W;

    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               is_arith;
    alu_flags_t         in_flags;
    alu_flags_t         head_flags;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] entry_head;

    // Carry is only meaningful for the adder path; logic ops report 0.
    assign is_arith = (in_op == OPW'(OP_ADD)) || (in_op == OPW'(OP_SUB));

    always_comb begin
        in_flags       = '0;
        in_flags.zero  = ~|in_y;
        in_flags.neg   = in_y[WIDTH-1];
        in_flags.par   = ^in_y;
        in_flags.carry = in_cout & is_arith;
    end

    assign entry_in  = {in_y, in_op, in_flags};
    assign in_ready  = ~full & rst_n;
    assign push      = in_valid & in_ready;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    alu_res_fifo2 #(
        .DW (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (entry_in),
        .full  (full),
        .empty (empty),
        .head  (entry_head)
    );

    assign {out_y, out_op, head_flags} = entry_head;
    assign out_zero  = head_flags.zero;
    assign out_neg   = head_flags.neg;
    assign out_carry = head_flags.carry;
    assign out_par   = head_flags.par;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_cnt <= '0;
        end else if (push) begin
            res_cnt <= res_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed pushes queue hand-computed entries,
// a negedge monitor compares every accepted output beat.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned OW = 2;
    localparam int unsigned CW = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_y;
    logic          in_cout;
    logic [OW-1:0] in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic [OW-1:0] out_op;
    logic          out_zero;
    logic          out_neg;
    logic          out_carry;
    logic          out_par;
    logic [CW-1:0] res_cnt;

    typedef struct packed {
        logic [W-1:0]  y;
        logic [OW-1:0] op;
        logic [3:0]    fl;
    } exp_t;

    exp_t          sb[$];
    int            n_run;
    int            n_fail;
    logic [CW-1:0] exp_cnt;
    int            w;

    alu_result_stage #(
        .WIDTH (W),
        .OPW   (OW),
        .CNTW  (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_cout   (in_cout),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_op    (out_op),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_carry (out_carry),
        .out_par   (out_par),
        .res_cnt   (res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare the head against the scoreboard on every handshake.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_output: got y=0x%0h with no entry expected", out_y);
            end else begin
                e = sb.pop_front();
                check("out_y", 32'(out_y), 32'(e.y));
                check("out_op", 32'(out_op), 32'(e.op));
                check("out_flags", 32'({out_par, out_carry, out_neg, out_zero}), 32'(e.fl));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic drive(input logic [3:0] y, input logic [1:0] op, input logic c,
                         input logic [3:0] fl, output int waited);
        exp_t t;
        logic done;
        in_valid = 1'b1;
        in_y     = y;
        in_op    = op;
        in_cout  = c;
        waited   = 0;
        done     = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                t.y  = y;
                t.op = op;
                t.fl = fl;
                sb.push_back(t);
                exp_cnt++;
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_run++;
            n_fail++;
            $display("FAIL drive_timeout: y=0x%0h never accepted", y);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    logic [3:0] t4_fl [8];
    logic [1:0] t6_cnt [5];

    initial begin
        t4_fl  = '{4'b0001, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
        t6_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        n_run     = 0;
        n_fail    = 0;
        exp_cnt   = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_y      = 4'hA;
        in_op     = OP_ADD;
        in_cout   = 1'b1;
        out_ready = 1'b1;

        // 1. reset held 3 clocks with in_valid asserted
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res_cnt", 32'(res_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("no_push_in_rst", 32'(res_cnt), 32'd0);

        // 2. single OR result, carry masked
        drive(4'b0111, OP_OR, 1'b1, 4'b1000, w);
        check("t2_latency_valid", 32'(out_valid), 32'd1);
        check("t2_res_cnt", 32'(res_cnt), 32'd1);
        wait_drain();

        // 3. backpressure with two held entries
        out_ready = 1'b0;
        drive(4'h3, OP_AND, 1'b0, 4'b0000, w);
        drive(4'h0, OP_AND, 1'b1, 4'b0001, w);
        check("t3_full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_y     = 4'h9;
        in_op    = OP_OR;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_held_off", 32'(in_ready), 32'd0);
            check("t3_head_hold", 32'(out_y), 32'h3);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("t3_res_cnt", 32'(res_cnt), 32'(exp_cnt));
        out_ready = 1'b1;
        wait_drain();
        check("t3_empty_valid", 32'(out_valid), 32'd0);

        // 4. streaming at occupancy 1
        for (int i = 0; i < 8; i++) begin
            drive(4'(i), OP_OR, 1'b1, t4_fl[i], w);
            check("t4_no_stall", 32'(w), 32'd0);
        end
        wait_drain();
        check("t4_last_hold", 32'(out_y), 32'h7);
        check("t4_res_cnt", 32'(res_cnt), 32'(exp_cnt));

        // 5. arithmetic carry and negative flags
        drive(4'h2, OP_ADD, 1'b1, 4'b1100, w);
        drive(4'hF, OP_SUB, 1'b0, 4'b0010, w);
        wait_drain();
        check("t5_empty_hold_y", 32'(out_y), 32'hF);
        check("t5_empty_valid", 32'(out_valid), 32'd0);

        // 6. counter wrap, then reset with two entries held
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = '0;
        for (int i = 0; i < 5; i++) begin
            drive(4'h1, OP_AND, 1'b0, 4'b1000, w);
            check("t6_res_cnt", 32'(res_cnt), 32'(t6_cnt[i]));
        end
        wait_drain();
        out_ready = 1'b0;
        drive(4'h5, OP_OR, 1'b0, 4'b0000, w);
        drive(4'h8, OP_ADD, 1'b1, 4'b1110, w);
        check("t6_full_valid", 32'(out_valid), 32'd1);
        check("t6_full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_cnt", 32'(res_cnt), 32'd0);
        check("t6_rst_y", 32'(out_y), 32'd0);
        check("t6_rst_flags", 32'({out_par, out_carry, out_neg, out_zero}), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_discarded", 32'(out_valid), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
